// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it, and serves bypassed ID/debug reads plus a registered commit trace.
module wb_regfile #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     read_data_in,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic                      reg_write_in,
  input  logic                      mem_to_reg_in,
  input  logic                      is_jal_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0]     rs_data,
  output logic [DATA_WIDTH-1:0]     rt_data,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic                      commit_valid,
  output logic [REG_ADDR_WIDTH-1:0] commit_reg,
  output logic [DATA_WIDTH-1:0]     commit_data,
  output logic [31:0]               commit_count
);

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];
  logic                      commit_valid_q, commit_valid_d;
  logic [REG_ADDR_WIDTH-1:0] commit_reg_q, commit_reg_d;
  logic [DATA_WIDTH-1:0]     commit_data_q, commit_data_d;
  logic [31:0]               commit_count_q, commit_count_d;
  logic                      we;

  assign wb_data_out = is_jal_in     ? pc_plus_4_in :
                       mem_to_reg_in ? read_data_in : alu_result_in;

  // r0 is hardwired to zero, so writes to it are not real commits.
  assign we = reg_write_in && (write_register_in != '0);

  assign rs_data  = (rs_addr == '0) ? '0 :
                    (we && rs_addr == write_register_in) ? wb_data_out : regs_q[rs_addr];
  assign rt_data  = (rt_addr == '0) ? '0 :
                    (we && rt_addr == write_register_in) ? wb_data_out : regs_q[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 :
                    (we && dbg_addr == write_register_in) ? wb_data_out : regs_q[dbg_addr];

  always_comb begin
    regs_d         = regs_q;
    commit_valid_d = we;
    commit_reg_d   = commit_reg_q;
    commit_data_d  = commit_data_q;
    commit_count_d = commit_count_q;
    if (we) begin
      regs_d[write_register_in] = wb_data_out;
      commit_reg_d              = write_register_in;
      commit_data_d             = wb_data_out;
      commit_count_d            = commit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      commit_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
      commit_count_q <= commit_count_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_reg   = commit_reg_q;
  assign commit_data  = commit_data_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table plus hand-written
// sequences for reset, register fill and commit counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, read_data_in, pc_plus_4_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in, mem_to_reg_in, is_jal_in;
  logic [4:0]  rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wb_data_out;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data, commit_count;

  int passCount = 0;
  int totalCount = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in), .pc_plus_4_in(pc_plus_4_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .is_jal_in(is_jal_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_data_out(wb_data_out),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_data(commit_data),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] alu, ld, pc4;
    logic [4:0]  wr;
    logic        rw, m2r, jal;
    logic [4:0]  rs, rt, dbg;
    logic [31:0] expWb, expRs, expRt, expDbg;
    logic        expCv;
    logic [4:0]  expCreg;
    logic [31:0] expCdata, expCount;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                               input logic [4:0] wr, input logic rw, input logic m2r, input logic jal,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    alu_result_in = alu; read_data_in = ld; pc_plus_4_in = pc4;
    write_register_in = wr; reg_write_in = rw; mem_to_reg_in = m2r; is_jal_in = jal;
    rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
  endtask

  task automatic idleInputs();
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // alu ld pc4 wr rw m2r jal rs rt dbg | wb rs rt dbg | cv creg cdata count
    vecs[0] = '{32'hA, 32'hB, 32'hC, 5'd3, 1, 0, 0, 5'd3, 5'd0, 5'd3, 32'hA, 32'hA, 32'h0, 32'hA, 1, 5'd3, 32'hA, 32'd1};
    vecs[1] = '{32'hA, 32'hB, 32'hC, 5'd3, 1, 1, 0, 5'd3, 5'd0, 5'd3, 32'hB, 32'hB, 32'h0, 32'hB, 1, 5'd3, 32'hB, 32'd2};
    vecs[2] = '{32'hA, 32'hB, 32'hC, 5'd3, 1, 0, 1, 5'd3, 5'd0, 5'd3, 32'hC, 32'hC, 32'h0, 32'hC, 1, 5'd3, 32'hC, 32'd3};
    vecs[3] = '{32'hA, 32'hB, 32'hC, 5'd3, 1, 1, 1, 5'd3, 5'd0, 5'd3, 32'hC, 32'hC, 32'h0, 32'hC, 1, 5'd3, 32'hC, 32'd4};
    vecs[4] = '{32'hA, 32'hB, 32'hC, 5'd3, 0, 0, 0, 5'd3, 5'd3, 5'd3, 32'hA, 32'hC, 32'hC, 32'hC, 0, 5'd3, 32'hC, 32'd4};
    vecs[5] = '{32'hDEAD, 32'h0, 32'h0, 5'd7, 1, 0, 0, 5'd7, 5'd7, 5'd7, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 1, 5'd7, 32'hDEAD, 32'd5};
    vecs[6] = '{32'h0, 32'h0, 32'h0, 5'd7, 0, 0, 0, 5'd7, 5'd7, 5'd7, 32'h0, 32'hDEAD, 32'hDEAD, 32'hDEAD, 0, 5'd7, 32'hDEAD, 32'd5};
    vecs[7] = '{32'hFFFF, 32'h0, 32'h0, 5'd0, 1, 0, 0, 5'd0, 5'd7, 5'd0, 32'hFFFF, 32'h0, 32'hDEAD, 32'h0, 0, 5'd7, 32'hDEAD, 32'd5};
    vecs[8] = '{32'h55, 32'h0, 32'h0, 5'd9, 1, 0, 0, 5'd3, 5'd9, 5'd7, 32'h55, 32'hC, 32'h55, 32'hDEAD, 1, 5'd9, 32'h55, 32'd6};
    vecs[9] = '{32'h99, 32'h0, 32'h0, 5'd3, 0, 0, 0, 5'd3, 5'd7, 5'd9, 32'h99, 32'hC, 32'hDEAD, 32'h55, 0, 5'd9, 32'h55, 32'd6};

    reset = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset clears the array and trace; a write pending during reset is dropped.
    applyStimulus(32'h1234, 32'h0, 32'h0, 5'd5, 1, 0, 0, 5'd0, 5'd0, 5'd5);
    @(posedge clk); #1;
    checkOutput("pre_reset_dbg_r5", dbg_data, 32'h1234);
    checkOutput("pre_reset_count", commit_count, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'h777, 32'h0, 32'h0, 5'd6, 1, 0, 0, 5'd0, 5'd0, 5'd5);
    @(negedge clk);
    reset = 1'b1;
    idleInputs();
    dbg_addr = 5'd5;
    #1;
    checkOutput("reset_dbg_r5", dbg_data, 32'h0);
    dbg_addr = 5'd6;
    #1;
    checkOutput("reset_dbg_r6_dropped", dbg_data, 32'h0);
    checkOutput("reset_count", commit_count, 32'h0);
    checkOutput("reset_valid", {31'b0, commit_valid}, 32'h0);
    checkOutput("reset_creg", {27'b0, commit_reg}, 32'h0);
    checkOutput("reset_cdata", commit_data, 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].alu, vecs[i].ld, vecs[i].pc4, vecs[i].wr, vecs[i].rw, vecs[i].m2r,
                    vecs[i].jal, vecs[i].rs, vecs[i].rt, vecs[i].dbg);
      #1;
      checkOutput($sformatf("v%0d_wb", i), wb_data_out, vecs[i].expWb);
      checkOutput($sformatf("v%0d_rs", i), rs_data, vecs[i].expRs);
      checkOutput($sformatf("v%0d_rt", i), rt_data, vecs[i].expRt);
      checkOutput($sformatf("v%0d_dbg", i), dbg_data, vecs[i].expDbg);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_cvalid", i), {31'b0, commit_valid}, {31'b0, vecs[i].expCv});
      checkOutput($sformatf("v%0d_creg", i), {27'b0, commit_reg}, {27'b0, vecs[i].expCreg});
      checkOutput($sformatf("v%0d_cdata", i), commit_data, vecs[i].expCdata);
      checkOutput($sformatf("v%0d_count", i), commit_count, vecs[i].expCount);
    end

    // Fill every writable register from a clean reset, then sweep the debug port.
    doReset();
    for (int n = 1; n < 32; n++) begin
      applyStimulus(n * 32'h11, 32'h0, 32'h0, n[4:0], 1, 0, 0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
    end
    idleInputs();
    #1;
    checkOutput("fill_count", commit_count, 32'd31);
    for (int n = 0; n < 32; n++) begin
      dbg_addr = n[4:0];
      #1;
      checkOutput($sformatf("fill_dbg_r%0d", n), dbg_data, n * 32'h11);
    end

    // Preload the counter just below wrap, then one real write must roll it to zero.
    @(negedge clk);
    force dut.commit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count_q;
    #1;
    checkOutput("wrap_preload", commit_count, 32'hFFFF_FFFF);
    applyStimulus(32'h42, 32'h0, 32'h0, 5'd4, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    checkOutput("wrap_count", commit_count, 32'h0);
    checkOutput("wrap_cvalid", {31'b0, commit_valid}, 32'h1);
    @(negedge clk);
    idleInputs();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
